alu_8bit: RTL and testbench
===========================

# alu_8bit

Registered 8-bit signed arithmetic/logic unit for the CPU datapath. It combines two 8-bit two's-complement operands under a 3-bit operation select and registers the result plus a zero flag on the clock edge. The control unit drives `sel`; the register file drives `A` and `B`. The result feeds write-back, and the zero flag feeds branch logic.

## Interface
- Parameters: none. Width is fixed at 8 bits.
- Clocking: one clock; reset is asynchronous and active-high.
- Port order for positional instantiation: clk, rst, A, B, out, zero, sel.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `A`  input  8  operand A, signed two's complement.
- `B`  input  8  operand B, signed two's complement.
- `out`  output  8  registered result.
- `zero`  output  1  registered flag; 1 when the registered `out` is 8'h00.
- `sel`  input  3  operation select.

## Operation
Operation select (result width 8 bits; higher bits discarded):
- 3'b000 ADD: A + B, modulo 2^8. No carry or overflow output.
- 3'b001 SUB: A − B, modulo 2^8.
- 3'b010 AND: A & B, bitwise.
- 3'b011 OR: A | B, bitwise.
- 3'b100 SLT: 8'h01 if A < B as signed values, else 8'h00.
- 3'b101 XOR: A ^ B.
- 3'b110 NOR: ~(A | B).
- 3'b111 PASS: A.

General rules:
- All comparisons are signed; 8'h80 is −128.
- `zero` is computed from the same next-result value that is loaded into `out`, so the two registers are always consistent.
- No illegal opcodes exist. Every `sel` value has a defined result.

## Timing
- Reset: when `rst` is asserted, `out` = 8'h00 and `zero` = 1 immediately, without waiting for a clock edge.
- Reset is held while asserted. Clock edges during reset are ignored.
- Reset deassertion takes effect at the next rising edge. That edge captures the current A, B and sel.
- Latency is 1 cycle. Inputs sampled at rising edge N appear on `out`/`zero` right after edge N.
- The result is registered on every edge; there is no enable and no handshake. The unit is fully pipelined with throughput 1 operation per cycle.
- Changing `sel`, `A` or `B` mid-cycle has no output effect until the next edge.
- The next-state logic is purely combinational. It contains no latches and has no multi-cycle paths.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle with `out` non-zero -> `out` = 8'h00 and `zero` = 1 at once. After release, the first edge loads a valid result.
- A = 8'h0F, B = 8'h5A, sweep sel 000..111, one per cycle -> ADD 8'h69, SUB 8'hB5, AND 8'h0A, OR 8'h5F, SLT 8'h01, XOR 8'h55, NOR 8'hA0, PASS 8'h0F. `zero` = 0 throughout.
- A = 8'hAA (−86), B = 8'hBB (−69) -> ADD wraps to 8'h65, SUB 8'hEF (−17), AND 8'hAA, OR 8'hBB, SLT 8'h01.
- A = 8'h0F, B = 8'hF0 (−16) -> AND 8'h00 with `zero` = 1. OR 8'hFF, ADD 8'hFF, SLT 8'h00 with `zero` = 1.
- Signed SLT boundaries: A = 8'h80, B = 8'h7F -> 8'h01. A = 8'h7F, B = 8'h80 -> 8'h00. A = B = 8'h33 -> 8'h00 with `zero` = 1.
- Latency check: change inputs every cycle for 20 random vectors -> each result appears exactly one edge after its inputs are sampled, and `zero` matches (out == 0).

Source files
------------

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit signed arithmetic/logic unit for the CPU datapath.
// Combines two's-complement operands A and B under a 3-bit operation select and
// registers the result together with a zero flag derived from that same result.
//
// Ports:
//   clk   in   1  rising-edge clock
//   rst   in   1  asynchronous active-high reset (out = 8'h00, zero = 1)
//   A     in   8  operand A, signed two's complement
//   B     in   8  operand B, signed two's complement
//   out   out  8  registered result (one-cycle latency)
//   zero  out  1  registered flag, 1 when out is 8'h00
//   sel   in   3  operation select (ADD, SUB, AND, OR, SLT, XOR, NOR, PASS)
module alu_8bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] out,
  output logic       zero,
  input  logic [2:0] sel
);

  localparam int unsigned W = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_SLT  = 3'b100,
    OP_XOR  = 3'b101,
    OP_NOR  = 3'b110,
    OP_PASS = 3'b111
  } op_e;

  logic [W-1:0] result_c;
  logic         less_c;

  // Signed compare: 8'h80 is the most negative operand.
  assign less_c = ($signed(A) < $signed(B));

  // Next-result selection; sums wrap modulo 2^8 by truncation.
  always_comb begin
    result_c = '0;
    case (op_e'(sel))
      OP_ADD:  result_c = W'(A + B);
      OP_SUB:  result_c = W'(A - B);
      OP_AND:  result_c = A & B;
      OP_OR:   result_c = A | B;
      OP_SLT:  result_c = W'(less_c);
      OP_XOR:  result_c = A ^ B;
      OP_NOR:  result_c = ~(A | B);
      OP_PASS: result_c = A;
      default: result_c = '0;
    endcase
  end

  // Result and flag registered from the same next value so they never disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out  <= '0;
      zero <= 1'b1;
    end else begin
      out  <= result_c;
      zero <= (result_c == '0);
    end
  end

endmodule

// File: tb/tb_alu_8bit.sv
// Self-checking bench for alu_8bit: directed vector table, reset/timing
// sequences, and randomized vectors against an arithmetic reference model.
module tb_alu_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] out;
  logic       zero;
  logic [2:0] sel;

  int checks;
  int failures;

  alu_8bit dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .out  (out),
    .zero (zero),
    .sel  (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] exp_out;
    logic       exp_zero;
  } vec_t;

  vec_t vecs[$];

  // Reference model using signed integer arithmetic, reduced modulo 256.
  function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [2:0] op);
    int sa;
    int sb;
    int ua;
    int ub;
    int r;
    sa = (a >= 8'd128) ? int'(a) - 256 : int'(a);
    sb = (b >= 8'd128) ? int'(b) - 256 : int'(b);
    ua = int'(a);
    ub = int'(b);
    case (op)
      3'd0:    r = sa + sb;
      3'd1:    r = sa - sb;
      3'd2:    r = ua & ub;
      3'd3:    r = ua | ub;
      3'd4:    r = (sa < sb) ? 1 : 0;
      3'd5:    r = ua ^ ub;
      3'd6:    r = 255 - (ua | ub);
      default: r = ua;
    endcase
    r = ((r % 256) + 256) % 256;
    return 8'(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample #1 after the next edge.
  task automatic apply(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    A   = a;
    B   = b;
    sel = op;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input logic [7:0] eo, input logic ez);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.exp_out = eo; v.exp_zero = ez;
    vecs.push_back(v);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    A   = 8'h00;
    B   = 8'h00;
    sel = 3'b000;

    // Operand sweep from the test plan.
    add_vec(8'h0F, 8'h5A, 3'b000, 8'h69, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b001, 8'hB5, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b010, 8'h0A, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b011, 8'h5F, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b100, 8'h01, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b101, 8'h55, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b110, 8'hA0, 1'b0);
    add_vec(8'h0F, 8'h5A, 3'b111, 8'h0F, 1'b0);
    // Negative operands.
    add_vec(8'hAA, 8'hBB, 3'b000, 8'h65, 1'b0);
    add_vec(8'hAA, 8'hBB, 3'b001, 8'hEF, 1'b0);
    add_vec(8'hAA, 8'hBB, 3'b010, 8'hAA, 1'b0);
    add_vec(8'hAA, 8'hBB, 3'b011, 8'hBB, 1'b0);
    add_vec(8'hAA, 8'hBB, 3'b100, 8'h01, 1'b0);
    // Zero-flag cases.
    add_vec(8'h0F, 8'hF0, 3'b010, 8'h00, 1'b1);
    add_vec(8'h0F, 8'hF0, 3'b011, 8'hFF, 1'b0);
    add_vec(8'h0F, 8'hF0, 3'b000, 8'hFF, 1'b0);
    add_vec(8'h0F, 8'hF0, 3'b100, 8'h00, 1'b1);
    // Signed SLT boundaries.
    add_vec(8'h80, 8'h7F, 3'b100, 8'h01, 1'b0);
    add_vec(8'h7F, 8'h80, 3'b100, 8'h00, 1'b1);
    add_vec(8'h33, 8'h33, 3'b100, 8'h00, 1'b1);
    // Extra wrap corners.
    add_vec(8'h7F, 8'h01, 3'b000, 8'h80, 1'b0);
    add_vec(8'h80, 8'h01, 3'b001, 8'h7F, 1'b0);
    add_vec(8'h00, 8'h00, 3'b110, 8'hFF, 1'b0);

    // Reset held from time zero: outputs forced, edges ignored.
    A = 8'h12; B = 8'h34; sel = 3'b000;
    #2;
    chk("reset_out_initial", out, 8'h00);
    chk("reset_zero_initial", 8'(zero), 8'h01);
    @(posedge clk); #1;
    chk("reset_out_held_edge", out, 8'h00);
    chk("reset_zero_held_edge", 8'(zero), 8'h01);

    // Release mid-cycle: nothing changes until the next edge, which loads a result.
    #2;
    rst = 1'b0;
    #1;
    chk("release_no_edge_out", out, 8'h00);
    @(posedge clk); #1;
    chk("release_first_edge_out", out, 8'h46);
    chk("release_first_edge_zero", 8'(zero), 8'h00);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].a, vecs[i].b, vecs[i].op);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d_zero", i), 8'(zero), 8'(vecs[i].exp_zero));
    end

    // Mid-cycle input change has no effect until the next edge.
    apply(8'h21, 8'h10, 3'b000);
    chk("midcycle_base", out, 8'h31);
    #2;
    A = 8'h00; B = 8'h00; sel = 3'b010;
    #1;
    chk("midcycle_hold_out", out, 8'h31);
    chk("midcycle_hold_zero", 8'(zero), 8'h00);
    @(posedge clk); #1;
    chk("midcycle_next_out", out, 8'h00);
    chk("midcycle_next_zero", 8'(zero), 8'h01);

    // Asynchronous reset mid-cycle with a non-zero output.
    apply(8'h5C, 8'h00, 3'b111);
    chk("pre_async_out", out, 8'h5C);
    #3;
    rst = 1'b1;
    #1;
    chk("async_reset_out", out, 8'h00);
    chk("async_reset_zero", 8'(zero), 8'h01);
    A = 8'h77; B = 8'h11; sel = 3'b011;
    @(posedge clk); #1;
    chk("async_reset_held_out", out, 8'h00);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_async_release_out", out, 8'h77);

    // Randomized back-to-back vectors against the model, one result per edge.
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [2:0] rs;
      logic [7:0] exp;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 3'($urandom_range(0, 7));
      if (i % 16 == 0) rb = ra;
      exp = model(ra, rb, rs);
      apply(ra, rb, rs);
      chk($sformatf("rand%0d_out(a=%h b=%h sel=%0d)", i, ra, rb, rs), out, exp);
      chk($sformatf("rand%0d_zero", i), 8'(zero), 8'(exp == 8'h00));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
